// File: rtl/snake_pkg.sv
// Shared types and constants for the frame demultiplexer slice.
package snake_pkg;

  localparam int PIXEL_W = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUTE_A = 2'd1,
    ROUTE_B = 2'd2
  } route_state_e;

endpackage

// File: rtl/demux_skid_buf.sv
// Output register shared by both demux outputs; with FRAME_DEMUX_SKID_EN a
// 2-entry skid buffer sits in front of it and in_ready_o becomes a register.
module demux_skid_buf #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i
);

  logic         out_valid_q;
  logic [W-1:0] out_data_q;

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

`ifdef FRAME_DEMUX_SKID_EN

  logic [W-1:0] skid0_q, skid0_d;
  logic [W-1:0] skid1_q, skid1_d;
  logic [1:0]   count_q, count_d;
  logic         ready_q;
  logic         out_valid_d;
  logic [W-1:0] out_data_d;
  logic         push;
  logic         out_free;

  assign in_ready_o = ready_q;
  assign push       = in_valid_i && ready_q;
  assign out_free   = !out_valid_q || out_ready_i;

  // Skid entries drain into the output register first so beat order is kept;
  // an empty skid lets a fresh beat go straight to the output (1-cycle latency).
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    skid0_d     = skid0_q;
    skid1_d     = skid1_q;
    count_d     = count_q;
    if (out_free) begin
      if (count_q == 2'd0) begin
        out_valid_d = push;
        if (push) out_data_d = in_data_i;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = skid0_q;
        skid0_d     = skid1_q;
        if (push) begin
          if (count_q == 2'd1) skid0_d = in_data_i;
          else                 skid1_d = in_data_i;
        end else begin
          count_d = count_q - 2'd1;
        end
      end
    end else if (push) begin
      if (count_q == 2'd0) skid0_d = in_data_i;
      else                 skid1_d = in_data_i;
      count_d = count_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
      ready_q     <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      skid0_q     <= skid0_d;
      skid1_q     <= skid1_d;
      count_q     <= count_d;
      ready_q     <= (count_d != 2'd2);
    end
  end

`else

  assign in_ready_o = !out_valid_q || out_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else if (in_ready_o) begin
      out_valid_q <= in_valid_i;
      if (in_valid_i) out_data_q <= in_data_i;
    end
  end

`endif

endmodule

// File: rtl/frame_demux_1to2.sv
// Routes whole frames from one stream to buffer A or B, locking the destination
// at the first beat. Build option FRAME_DEMUX_SKID_EN selects the skid buffer.
module frame_demux_1to2
  import snake_pkg::*;
#(
  parameter int DATA_W = PIXEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              sel,
  output logic              m_a_valid,
  output logic [DATA_W-1:0] m_a_data,
  output logic              m_a_last,
  input  logic              m_a_ready,
  output logic              m_b_valid,
  output logic [DATA_W-1:0] m_b_data,
  output logic              m_b_last,
  input  logic              m_b_ready,
  output logic              active_sel,
  output logic              frame_done
);

  localparam int PW = DATA_W + 2;

  route_state_e    state_q;
  logic            active_sel_q;
  logic            frame_done_q;
  logic            buf_in_ready;
  logic            out_valid;
  logic [PW-1:0]   out_payload;
  logic            beat_dest;
  logic            s_fire;
  logic            out_dest;
  logic            out_last;
  logic            out_ready;
  logic            out_fire;

  assign s_ready   = rst_n && buf_in_ready;
  assign s_fire    = s_valid && s_ready;
  // The first beat of a frame follows sel directly; later beats use the lock.
  assign beat_dest = (state_q == IDLE) ? sel : (state_q == ROUTE_B);

  demux_skid_buf #(.W(PW)) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (s_valid),
    .in_data_i   ({beat_dest, s_last, s_data}),
    .in_ready_o  (buf_in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_payload),
    .out_ready_i (out_ready)
  );

  assign out_dest  = out_payload[PW-1];
  assign out_last  = out_payload[PW-2];
  assign out_ready = out_dest ? m_b_ready : m_a_ready;
  assign out_fire  = out_valid && out_ready;

  assign m_a_valid  = out_valid && !out_dest;
  assign m_b_valid  = out_valid && out_dest;
  assign m_a_data   = out_payload[DATA_W-1:0];
  assign m_b_data   = out_payload[DATA_W-1:0];
  assign m_a_last   = out_last;
  assign m_b_last   = out_last;
  assign active_sel = active_sel_q;
  assign frame_done = frame_done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      active_sel_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= out_fire && out_last;
      if (s_fire) begin
        case (state_q)
          IDLE: begin
            active_sel_q <= sel;
            if (!s_last) state_q <= sel ? ROUTE_B : ROUTE_A;
          end
          default: begin
            if (s_last) state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_demux_1to2.sv
// Self-checking bench for frame_demux_1to2: directed vector table, stall and
// reset sequences, then randomized frames against a queue-based frame model.
module tb_frame_demux_1to2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [11:0] s_data = 12'd0;
  logic        s_last = 1'b0;
  logic        sel = 1'b0;
  logic        s_ready;
  logic        m_a_valid;
  logic [11:0] m_a_data;
  logic        m_a_last;
  logic        m_a_ready = 1'b1;
  logic        m_b_valid;
  logic [11:0] m_b_data;
  logic        m_b_last;
  logic        m_b_ready = 1'b1;
  logic        active_sel;
  logic        frame_done;

  typedef struct {
    logic [11:0] data;
    logic        last;
    logic        selIn;
    logic        expDest;
  } vec_t;

  vec_t        tbl[16];
  int          checks = 0;
  int          failures = 0;
  logic [12:0] qa[$];
  logic [12:0] qb[$];
  logic        inFrame = 1'b0;
  logic        lockDest = 1'b0;
  logic        expActive = 1'b0;
  logic        expDone = 1'b0;
  logic        prevStallA = 1'b0;
  logic        prevStallB = 1'b0;
  logic [12:0] prevBeatA = 13'd0;
  logic [12:0] prevBeatB = 13'd0;
  logic        pendValid = 1'b0;
  int          pendIdx = 0;
  int          doneCount = 0;
  int          cycleCount = 0;
  logic        stallA = 1'b0;
  logic        randomSink = 1'b0;

  frame_demux_1to2 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .sel        (sel),
    .m_a_valid  (m_a_valid),
    .m_a_data   (m_a_data),
    .m_a_last   (m_a_last),
    .m_a_ready  (m_a_ready),
    .m_b_valid  (m_b_valid),
    .m_b_data   (m_b_data),
    .m_b_last   (m_b_last),
    .m_b_ready  (m_b_ready),
    .active_sel (active_sel),
    .frame_done (frame_done)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one beat and hold it until the DUT accepts it (bounded wait).
  task automatic applyStimulus(input logic [11:0] d, input logic l, input logic s);
    int waitCnt;
    waitCnt = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    sel     = s;
    @(negedge clk);
    while (!s_ready && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!s_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL send_timeout: s_ready got 0, expected 1");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic readyDriver();
    forever begin
      @(posedge clk);
      #2;
      if (randomSink) begin
        m_a_ready = ($urandom_range(0, 3) != 0);
        m_b_ready = ($urandom_range(0, 3) != 0);
      end else begin
        m_a_ready = !stallA;
        m_b_ready = 1'b1;
      end
    end
  endtask

  // Frame-level reference: beats are queued per destination chosen at frame start.
  task automatic monitorLoop();
    logic [12:0] expBeat;
    vec_t        v;
    forever begin
      @(negedge clk);
      cycleCount++;
      checkOutput("frame_done", 32'(frame_done), 32'(expDone));
      checkOutput("active_sel", 32'(active_sel), 32'(expActive));
      checkOutput("valid_exclusive", 32'(m_a_valid & m_b_valid), 32'd0);
      if (frame_done) doneCount++;
      if (prevStallA) begin
        checkOutput("hold_a_valid", 32'(m_a_valid), 32'd1);
        checkOutput("hold_a_beat", 32'({m_a_last, m_a_data}), 32'(prevBeatA));
      end
      if (prevStallB) begin
        checkOutput("hold_b_valid", 32'(m_b_valid), 32'd1);
        checkOutput("hold_b_beat", 32'({m_b_last, m_b_data}), 32'(prevBeatB));
      end
      if (pendValid) begin
        v = tbl[pendIdx];
        if (v.expDest) begin
          checkOutput("tbl_b_valid", 32'(m_b_valid), 32'd1);
          checkOutput("tbl_a_valid", 32'(m_a_valid), 32'd0);
          checkOutput("tbl_b_data", 32'(m_b_data), 32'(v.data));
          checkOutput("tbl_b_last", 32'(m_b_last), 32'(v.last));
        end else begin
          checkOutput("tbl_a_valid", 32'(m_a_valid), 32'd1);
          checkOutput("tbl_b_valid", 32'(m_b_valid), 32'd0);
          checkOutput("tbl_a_data", 32'(m_a_data), 32'(v.data));
          checkOutput("tbl_a_last", 32'(m_a_last), 32'(v.last));
        end
        checkOutput("tbl_active_sel", 32'(active_sel), 32'(v.expDest));
        pendValid = 1'b0;
      end
      if (!rst_n) begin
        checkOutput("s_ready_in_reset", 32'(s_ready), 32'd0);
        qa.delete();
        qb.delete();
        inFrame    = 1'b0;
        expActive  = 1'b0;
        expDone    = 1'b0;
        prevStallA = 1'b0;
        prevStallB = 1'b0;
      end else begin
        expDone = 1'b0;
        if (m_a_valid && m_a_ready) begin
          if (qa.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL a_unexpected: got beat 0x%0h, expected none", {m_a_last, m_a_data});
          end else begin
            expBeat = qa.pop_front();
            checkOutput("a_beat", 32'({m_a_last, m_a_data}), 32'(expBeat));
          end
          if (m_a_last) expDone = 1'b1;
        end
        if (m_b_valid && m_b_ready) begin
          if (qb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL b_unexpected: got beat 0x%0h, expected none", {m_b_last, m_b_data});
          end else begin
            expBeat = qb.pop_front();
            checkOutput("b_beat", 32'({m_b_last, m_b_data}), 32'(expBeat));
          end
          if (m_b_last) expDone = 1'b1;
        end
        prevStallA = m_a_valid && !m_a_ready;
        prevStallB = m_b_valid && !m_b_ready;
        prevBeatA  = {m_a_last, m_a_data};
        prevBeatB  = {m_b_last, m_b_data};
        if (s_valid && s_ready) begin
          if (!inFrame) begin
            lockDest  = sel;
            expActive = sel;
          end
          if (lockDest) qb.push_back({s_last, s_data});
          else          qa.push_back({s_last, s_data});
          inFrame = !s_last;
        end
      end
    end
  endtask

  task automatic runTest();
    int   cyc0;
    int   done0;
    logic sawDrop;

    tbl[0]  = '{12'h001, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{12'h002, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{12'h003, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{12'h004, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{12'h011, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{12'h012, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{12'h013, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{12'h014, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{12'h015, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{12'h021, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{12'h022, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{12'h023, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{12'h031, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{12'h041, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{12'h042, 1'b0, 1'b1, 1'b1};
    tbl[15] = '{12'h043, 1'b1, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_a_valid", 32'(m_a_valid), 32'd0);
    checkOutput("reset_b_valid", 32'(m_b_valid), 32'd0);
    checkOutput("reset_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] directed frame table");
    cyc0  = cycleCount;
    done0 = doneCount;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i].data, tbl[i].last, tbl[i].selIn);
      pendIdx   = i;
      pendValid = 1'b1;
    end
    checkOutput("table_cycles", 32'(cycleCount - cyc0), 32'd16);
    repeat (3) @(posedge clk);
    checkOutput("table_frame_done", 32'(doneCount - done0), 32'd5);
    #1;

    $display("[TB] sink stall on m_a");
    applyStimulus(12'h0AA, 1'b0, 1'b0);
    applyStimulus(12'hABC, 1'b0, 1'b0);
    stallA  = 1'b1;
    sawDrop = 1'b0;
    fork
      begin
        applyStimulus(12'h0AD, 1'b0, 1'b1);
        applyStimulus(12'h0AE, 1'b1, 1'b1);
      end
      begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          checkOutput("stall_a_data", 32'(m_a_data), 32'hABC);
          checkOutput("stall_a_valid", 32'(m_a_valid), 32'd1);
          checkOutput("stall_b_valid", 32'(m_b_valid), 32'd0);
          if (!s_ready) sawDrop = 1'b1;
        end
        stallA = 1'b0;
      end
    join
    checkOutput("stall_s_ready_drop", 32'(sawDrop), 32'd1);
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] reset mid-frame");
    applyStimulus(12'h101, 1'b0, 1'b0);
    applyStimulus(12'h102, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_a_valid", 32'(m_a_valid), 32'd0);
    checkOutput("abort_b_valid", 32'(m_b_valid), 32'd0);
    checkOutput("abort_active_sel", 32'(active_sel), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(12'h201, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("after_reset_b_valid", 32'(m_b_valid), 32'd1);
    checkOutput("after_reset_b_data", 32'(m_b_data), 32'h201);
    checkOutput("after_reset_a_valid", 32'(m_a_valid), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(12'h202, 1'b0, 1'b0);
    applyStimulus(12'h203, 1'b1, 1'b0);

    $display("[TB] randomized frames");
    randomSink = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int   len;
      logic firstSel;
      len      = $urandom_range(1, 6);
      firstSel = 1'($urandom_range(0, 1));
      for (int b = 0; b < len; b++) begin
        logic beatSel;
        beatSel = (b == 0) ? firstSel : 1'($urandom_range(0, 1));
        applyStimulus(12'($urandom), (b == len - 1), beatSel);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    randomSink = 1'b0;
    repeat (20) @(posedge clk);
    checkOutput("drain_qa_empty", 32'(qa.size()), 32'd0);
    checkOutput("drain_qb_empty", 32'(qb.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    fork
      monitorLoop();
      readyDriver();
      runTest();
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
